// File: rtl/one_hz_cpu.sv
// one_hz_cpu: minimal non-pipelined RV32I core with separate instruction and data ports.
// Non-memory instructions retire on the edge their fetch response arrives; loads/stores
// take a second state that holds the data request until mem_resp.
// Optional macro ONE_HZ_CPU_TRACE_EN adds trace_valid/trace_rd/trace_rd_wdata outputs.
module one_hz_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        imem_read,
    input  logic        imem_resp,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp
`ifdef ONE_HZ_CPU_TRACE_EN
    ,
    output logic        trace_valid,
    output logic [4:0]  trace_rd,
    output logic [31:0] trace_rd_wdata
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {S_EXEC = 1'b0, S_MEM = 1'b1} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_regs [32];
    logic        r_mem_read;
    logic        r_mem_write;
    logic [3:0]  r_mbe;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [2:0]  r_f3;
    logic [1:0]  r_ea_lo;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_alu_b, w_alu_res;
    logic [4:0]  w_shamt;
    logic        w_br_taken;
    logic        w_is_load, w_is_store;
    logic [31:0] w_ea;
    logic        w_rd_we;
    logic [31:0] w_rd_data, w_next_pc;
    logic [3:0]  w_mbe;
    logic [31:0] w_st_wdata;
    logic [4:0]  w_ld_shamt;
    logic [31:0] w_ld_shift, w_ld_data;

    assign pc              = r_pc;
    assign imem_read       = (r_state == S_EXEC) && !rst;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;
    assign mem_read        = r_mem_read;
    assign mem_write       = r_mem_write;
    assign mem_byte_enable = r_mbe;

    // Field decode, immediates and register-file reads (x0 reads as zero).
    always_comb begin
        w_opcode   = instr[6:0];
        w_rd       = instr[11:7];
        w_f3       = instr[14:12];
        w_rs1      = instr[19:15];
        w_rs2      = instr[24:20];
        w_rs1_val  = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
        w_rs2_val  = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
        w_imm_i    = {{20{instr[31]}}, instr[31:20]};
        w_imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        w_imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        w_imm_u    = {instr[31:12], 12'd0};
        w_imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        w_is_load  = (w_opcode == OP_LOAD);
        w_is_store = (w_opcode == OP_STORE);
    end

    // Shared ALU for register-immediate and register-register operations.
    always_comb begin
        w_alu_b   = (w_opcode == OP_REG) ? w_rs2_val : w_imm_i;
        w_shamt   = w_alu_b[4:0];
        w_alu_res = '0;
        case (w_f3)
            3'b000:  w_alu_res = ((w_opcode == OP_REG) && instr[30]) ? (w_rs1_val - w_alu_b)
                                                                      : (w_rs1_val + w_alu_b);
            3'b001:  w_alu_res = w_rs1_val << w_shamt;
            3'b010:  w_alu_res = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011:  w_alu_res = {31'd0, w_rs1_val < w_alu_b};
            3'b100:  w_alu_res = w_rs1_val ^ w_alu_b;
            3'b101:  w_alu_res = instr[30] ? 32'($signed(w_rs1_val) >>> w_shamt)
                                           : (w_rs1_val >> w_shamt);
            3'b110:  w_alu_res = w_rs1_val | w_alu_b;
            default: w_alu_res = w_rs1_val & w_alu_b;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        w_br_taken = 1'b0;
        case (w_f3)
            3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_taken = (w_rs1_val < w_rs2_val);
            3'b111:  w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Writeback value and next pc for instructions that retire in EXEC.
    always_comb begin
        w_rd_we   = 1'b0;
        w_rd_data = '0;
        w_next_pc = r_pc + 32'd4;
        case (w_opcode)
            OP_LUI:    begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
            OP_AUIPC:  begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            OP_JAL:    begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            OP_JALR:   begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            OP_BRANCH: if (w_br_taken) w_next_pc = r_pc + w_imm_b;
            OP_IMM,
            OP_REG:    begin w_rd_we = 1'b1; w_rd_data = w_alu_res; end
            default:   w_rd_we = 1'b0;
        endcase
    end

    // Effective address, lane mask and lane-replicated store data.
    always_comb begin
        w_ea = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
        case (w_f3[1:0])
            2'b00:   begin w_mbe = 4'b0001 << w_ea[1:0];          w_st_wdata = {4{w_rs2_val[7:0]}};  end
            2'b01:   begin w_mbe = 4'b0011 << {w_ea[1], 1'b0};    w_st_wdata = {2{w_rs2_val[15:0]}}; end
            default: begin w_mbe = 4'b1111;                       w_st_wdata = w_rs2_val;            end
        endcase
    end

    // Load lane extraction and extension from the latched access fields.
    always_comb begin
        case (r_f3[1:0])
            2'b00:   w_ld_shamt = {r_ea_lo, 3'b000};
            2'b01:   w_ld_shamt = {r_ea_lo[1], 4'b0000};
            default: w_ld_shamt = 5'd0;
        endcase
        w_ld_shift = mem_rdata >> w_ld_shamt;
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
            3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
    end

    // Control FSM, pc, register file and registered data-port requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EXEC;
            r_pc        <= RESET_PC;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mbe       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
            r_f3        <= '0;
            r_ea_lo     <= '0;
        end else begin
            case (r_state)
                S_EXEC: if (imem_resp) begin
                    if (w_is_load || w_is_store) begin
                        r_mem_read  <= w_is_load;
                        r_mem_write <= w_is_store;
                        r_mbe       <= w_mbe;
                        r_addr      <= {w_ea[31:2], 2'b00};
                        r_wdata     <= w_st_wdata;
                        r_rd        <= w_rd;
                        r_f3        <= w_f3;
                        r_ea_lo     <= w_ea[1:0];
                        r_state     <= S_MEM;
                    end else begin
                        if (w_rd_we && (w_rd != 5'd0)) r_regs[w_rd] <= w_rd_data;
                        r_pc <= w_next_pc;
                    end
                end
                S_MEM: if (mem_resp) begin
                    if (r_mem_read && (r_rd != 5'd0)) r_regs[r_rd] <= w_ld_data;
                    r_pc        <= r_pc + 32'd4;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mbe       <= '0;
                    r_state     <= S_EXEC;
                end
                default: r_state <= S_EXEC;
            endcase
        end
    end

`ifdef ONE_HZ_CPU_TRACE_EN
    // Retirement trace, asserted in the cycle whose closing edge retires an instruction.
    always_comb begin
        trace_valid    = 1'b0;
        trace_rd       = '0;
        trace_rd_wdata = '0;
        if (!rst) begin
            if ((r_state == S_EXEC) && imem_resp && !(w_is_load || w_is_store)) begin
                trace_valid = 1'b1;
                if (w_rd_we && (w_rd != 5'd0)) begin
                    trace_rd       = w_rd;
                    trace_rd_wdata = w_rd_data;
                end
            end else if ((r_state == S_MEM) && mem_resp) begin
                trace_valid = 1'b1;
                if (r_mem_read && (r_rd != 5'd0)) begin
                    trace_rd       = r_rd;
                    trace_rd_wdata = w_ld_data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_one_hz_cpu.sv
// Self-checking bench for one_hz_cpu: directed scenarios plus random instruction
// streams checked against an instruction-level architectural model.
module tb_one_hz_cpu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        imem_read;
    logic        imem_resp;
    logic [31:0] mem_address;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;
`ifdef ONE_HZ_CPU_TRACE_EN
    logic        trace_valid;
    logic [4:0]  trace_rd;
    logic [31:0] trace_rd_wdata;
`endif

    one_hz_cpu dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .instr           (instr),
        .imem_read       (imem_read),
        .imem_resp       (imem_resp),
        .mem_address     (mem_address),
        .mem_rdata       (mem_rdata),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp)
`ifdef ONE_HZ_CPU_TRACE_EN
        ,
        .trace_valid     (trace_valid),
        .trace_rd        (trace_rd),
        .trace_rd_wdata  (trace_rd_wdata)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] RST_PC = 32'h0000_0060;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_x [32];
    logic [31:0] m_pc;
    logic [31:0] last_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // Architectural result of an ALU operation.
    function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input logic alt);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
        m_pc = RST_PC;
    endtask

    // Fetch one instruction; memory ops wait lat cycles before mem_resp with rdata.
    task automatic run(input logic [31:0] ins, input int lat, input logic [31:0] rdata);
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, ii, is, ib, iu, ij, ea, val, npc, sh, exp_w, msk;
        logic [3:0]  mbe;
        logic        wr, taken;
        op  = ins[6:0];  rd = ins[11:7]; f3 = ins[14:12]; rs1 = ins[19:15]; rs2 = ins[24:20];
        a   = m_x[rs1];  b  = m_x[rs2];
        ii  = {{20{ins[31]}}, ins[31:20]};
        is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = {ins[31:12], 12'd0};
        ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        chk("fetch_pc", pc, m_pc);
        chk("fetch_imem_read", 32'(imem_read), 32'd1);
        instr = ins; imem_resp = 1'b1;
        @(posedge clk); #1;
        imem_resp = 1'b0; instr = 32'd0;
        if (op == 7'b0000011 || op == 7'b0100011) begin
            ea = a + ((op == 7'b0100011) ? is : ii);
            if (f3[1:0] == 2'b00) begin
                mbe = 4'(1 << ea[1:0]); exp_w = {4{b[7:0]}};
            end else if (f3[1:0] == 2'b01) begin
                mbe = ea[1] ? 4'b1100 : 4'b0011; exp_w = {2{b[15:0]}};
            end else begin
                mbe = 4'b1111; exp_w = b;
            end
            msk = {{8{mbe[3]}}, {8{mbe[2]}}, {8{mbe[1]}}, {8{mbe[0]}}};
            for (int k = 0; k <= lat; k++) begin
                chk("mem_read_hold", 32'(mem_read), 32'(op == 7'b0000011));
                chk("mem_write_hold", 32'(mem_write), 32'(op == 7'b0100011));
                chk("mem_address", mem_address, {ea[31:2], 2'b00});
                chk("mem_byte_enable", 32'(mem_byte_enable), 32'(mbe));
                chk("mem_pc_stable", pc, m_pc);
                chk("mem_imem_read", 32'(imem_read), 32'd0);
                if (op == 7'b0100011) chk("mem_wdata_lanes", mem_wdata & msk, exp_w & msk);
                if (k == 0) last_wdata = mem_wdata;
                if (k == lat) begin
                    mem_resp = 1'b1; mem_rdata = rdata;
                end else begin
                    imem_resp = 1'b1; instr = 32'h0010_0093;
                    mem_rdata = 32'($urandom);
                end
                @(posedge clk); #1;
                mem_resp = 1'b0; imem_resp = 1'b0; instr = 32'd0;
            end
            chk("mem_req_drop", {30'd0, mem_read, mem_write}, 32'd0);
            if (op == 7'b0000011 && rd != 5'd0) begin
                sh = (f3[1:0] == 2'b00) ? rdata >> (8 * ea[1:0]) :
                     (f3[1:0] == 2'b01) ? rdata >> (16 * ea[1]) : rdata;
                case (f3)
                    3'd0:    m_x[rd] = {{24{sh[7]}}, sh[7:0]};
                    3'd1:    m_x[rd] = {{16{sh[15]}}, sh[15:0]};
                    3'd4:    m_x[rd] = {24'd0, sh[7:0]};
                    3'd5:    m_x[rd] = {16'd0, sh[15:0]};
                    default: m_x[rd] = sh;
                endcase
            end
            m_pc = m_pc + 32'd4;
        end else begin
            wr = 1'b0; val = 32'd0; npc = m_pc + 32'd4;
            case (op)
                7'b0110111: begin wr = 1'b1; val = iu; end
                7'b0010111: begin wr = 1'b1; val = m_pc + iu; end
                7'b1101111: begin wr = 1'b1; val = m_pc + 32'd4; npc = m_pc + ij; end
                7'b1100111: begin wr = 1'b1; val = m_pc + 32'd4; npc = (a + ii) & 32'hFFFF_FFFE; end
                7'b1100011: begin
                    case (f3)
                        3'd0:    taken = (a == b);
                        3'd1:    taken = (a != b);
                        3'd4:    taken = ($signed(a) < $signed(b));
                        3'd5:    taken = ($signed(a) >= $signed(b));
                        3'd6:    taken = (a < b);
                        default: taken = (a >= b);
                    endcase
                    if (taken) npc = m_pc + ib;
                end
                7'b0010011: begin wr = 1'b1; val = m_alu(f3, a, ii, (f3 == 3'd5) && ins[30]); end
                7'b0110011: begin wr = 1'b1; val = m_alu(f3, a, b, ins[30]); end
                default: wr = 1'b0;
            endcase
            if (wr && rd != 5'd0) m_x[rd] = val;
            m_pc = npc;
            chk("no_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
        end
    endtask

    // Read a register out through a word store and compare against a literal.
    task automatic reg_is(input string tag, input logic [4:0] r, input logic [31:0] v);
        run(enc_s(12'd0, r, 5'd0, 3'd2), 0, 32'd0);
        chk(tag, last_wdata, v);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; imem_resp = 1'b0; mem_resp = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            chk("rst_pc", pc, RST_PC);
            chk("rst_imem_read", 32'(imem_read), 32'd0);
            chk("rst_mem_req", {30'd0, mem_read, mem_write}, 32'd0);
            chk("rst_mbe", 32'(mem_byte_enable), 32'd0);
        end
        rst = 1'b0; #1;
        chk("post_rst_imem_read", 32'(imem_read), 32'd1);
        model_reset();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        int          t;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  return {20'($urandom), rd, 7'b0110111};
            1:  return {20'($urandom), rd, 7'b0010111};
            2:  return enc_j(21'($urandom), rd);
            3:  return enc_i(imm, rs1, 3'd0, rd, 7'b1100111);
            4:  begin t = $urandom_range(0, 5); return enc_b(13'($urandom), rs2, rs1, 3'((t < 2) ? t : t + 2)); end
            5, 6: begin
                if (f3 == 3'd1) imm[11:5] = 7'd0;
                if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
                return enc_i(imm, rs1, f3, rd, 7'b0010011);
            end
            7, 8: return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                               rs2, rs1, f3, rd);
            9:  begin t = $urandom_range(0, 4); return enc_i(imm, rs1, 3'((t < 3) ? t : t + 1), rd, 7'b0000011); end
            10: return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
            default: begin
                t = $urandom_range(0, 2);
                return (t == 0) ? 32'h0000_000F : (t == 1) ? 32'h0000_0073 : {25'($urandom), 7'b0001011};
            end
        endcase
    endfunction

    initial begin
        instr = 32'd0; mem_rdata = 32'd0;
        do_reset(5);

        // Back-to-back ADDI chain then ADD.
        run(enc_i(12'd15,   5'd0, 3'd0, 5'd1, 7'b0010011), 0, 0);
        run(enc_i(12'd31,   5'd0, 3'd0, 5'd2, 7'b0010011), 0, 0);
        run(enc_i(12'd63,   5'd0, 3'd0, 5'd3, 7'b0010011), 0, 0);
        run(enc_i(12'd127,  5'd0, 3'd0, 5'd4, 7'b0010011), 0, 0);
        run(enc_i(12'd255,  5'd0, 3'd0, 5'd5, 7'b0010011), 0, 0);
        run(enc_i(12'd511,  5'd0, 3'd0, 5'd7, 7'b0010011), 0, 0);
        run(enc_i(12'd1023, 5'd0, 3'd0, 5'd8, 7'b0010011), 0, 0);
        run(enc_i(12'd2047, 5'd0, 3'd0, 5'd9, 7'b0010011), 0, 0);
        run(enc_r(7'd0, 5'd1, 5'd2, 3'd0, 5'd10), 0, 0);
        chk("pc_after_chain", pc, 32'h0000_0084);
        reg_is("x1", 5'd1, 32'd15);
        reg_is("x4", 5'd4, 32'd127);
        reg_is("x6_untouched", 5'd6, 32'd0);
        reg_is("x9", 5'd9, 32'd2047);
        reg_is("x10_add", 5'd10, 32'd46);

        // Word store with 3 wait cycles.
        run({20'hAABBD, 5'd1, 7'b0110111}, 0, 0);
        run(enc_i(12'hCDD, 5'd1, 3'd0, 5'd1, 7'b0010011), 0, 0);
        reg_is("x1_const", 5'd1, 32'hAABB_CCDD);
        run(enc_s(12'd3, 5'd1, 5'd0, 3'd2), 3, 0);
        chk("sw_wdata", last_wdata, 32'hAABB_CCDD);

        // Signed and unsigned byte loads from lane 1.
        instr = enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'b0000011); imem_resp = 1'b1;
        @(posedge clk); #1; imem_resp = 1'b0;
        chk("lb_mbe", 32'(mem_byte_enable), 32'h2);
        chk("lb_addr", mem_address, 32'd0);
        mem_rdata = 32'h0000_8000; mem_resp = 1'b1;
        @(posedge clk); #1; mem_resp = 1'b0;
        m_x[5] = 32'hFFFF_FF80; m_pc = m_pc + 32'd4;
        reg_is("lb_sext", 5'd5, 32'hFFFF_FF80);
        run(enc_i(12'd1, 5'd0, 3'd4, 5'd5, 7'b0000011), 1, 32'h0000_8000);
        reg_is("lbu_zext", 5'd5, 32'h0000_0080);

        // BNE taken and not taken at pc 0x70.
        do_reset(2);
        run(enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'b0010011), 0, 0);
        run(enc_i(12'd2, 5'd0, 3'd0, 5'd2, 7'b0010011), 0, 0);
        run(32'h0000_0013, 0, 0);
        run(32'h0000_0013, 0, 0);
        chk("pc_before_bne", pc, 32'h70);
        run(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 0, 0);
        chk("bne_taken_pc", pc, 32'h68);
        run(enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'b0010011), 0, 0);
        run(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'b0010011), 0, 0);
        run(enc_b(13'h1FF8, 5'd2, 5'd1, 3'd1), 0, 0);
        chk("bne_not_taken_pc", pc, 32'h74);
        reg_is("x0_zero", 5'd0, 32'd0);

        // Fetch stall: no response for 4 cycles.
        repeat (4) begin
            @(posedge clk); #1;
            chk("stall_pc", pc, m_pc);
            chk("stall_imem_read", 32'(imem_read), 32'd1);
        end
        reg_is("x2_after_stall", 5'd2, 32'd1);

        // Reset while a store is outstanding.
        instr = enc_s(12'd0, 5'd1, 5'd0, 3'd2); imem_resp = 1'b1;
        @(posedge clk); #1; imem_resp = 1'b0;
        chk("midrst_write_active", 32'(mem_write), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_drop", {30'd0, mem_read, mem_write}, 32'd0);
        chk("midrst_pc", pc, RST_PC);
        rst = 1'b0; #1;
        model_reset();

        // Random instruction stream.
        for (int n = 0; n < 400; n++) run(rand_instr(), $urandom_range(0, 2), 32'($urandom));
        for (int r = 0; r < 32; r++) run(enc_s(12'd0, 5'(r), 5'd0, 3'd2), $urandom_range(0, 1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/one_hz_cpu.md
Name: one_hz_cpu

Overview:
- Minimal RV32I integer core: fetches one instruction at a time over a simple instruction port and executes it.
- Loads and stores go through a separate handshaked data port.
- Non-pipelined. An instruction with no memory access retires in the same clock cycle its fetch response arrives.
- Top-level CPU block. Instruction and data memories are external; the testbench interface supplies them.

Parameters:
- RESET_PC, 32'h0000_0060: value loaded into pc on reset.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  out  32  current instruction address (fetch address).
- instr  in  32  instruction word; valid when imem_resp=1.
- imem_read  out  1  instruction fetch request.
- imem_resp  in  1  instr valid this cycle.
- mem_address  out  32  data address, word aligned ({ea[31:2],2'b00}).
- mem_rdata  in  32  load data; valid when mem_resp=1.
- mem_wdata  out  32  store data, byte-lane aligned.
- mem_read  out  1  load request.
- mem_write  out  1  store request.
- mem_byte_enable  out  4  active byte lanes for the access.
- mem_resp  in  1  data access complete.

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc<=RESET_PC; state<=EXEC.
  - x1..x31<=0.
  - mem_read=mem_write=0, mem_byte_enable=0.
  - imem_read=0 while rst=1.
- x0 reads 0 always; writes to x0 are discarded.
- States:
  - EXEC: imem_read=1. The core waits for imem_resp=1 and holds pc while imem_resp=0.
    - On imem_resp=1 with a non-memory instruction: rd is written and pc updated at that clock edge (1-cycle latency). Back-to-back responses retire one instruction per cycle.
    - On imem_resp=1 with a LOAD/STORE: the instruction is latched, the effective address is computed, and the core moves to MEM. pc is unchanged.
  - MEM: imem_read=0. mem_read (loads) or mem_write (stores) is held high with stable mem_address, mem_wdata and mem_byte_enable until mem_resp=1.
    - On mem_resp=1: the load writes rd from mem_rdata, pc<=pc+4, state<=EXEC.
    - mem_read/mem_write drop in the following cycle.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Other opcodes (FENCE, SYSTEM, illegal): NOP with pc+4; no trap.
- Arithmetic: 32-bit wraparound with no overflow detection. Shift amount is low 5 bits. SLT is signed, SLTU unsigned; immediates are sign-extended per RV32I.
- Control flow:
  - Taken branch: pc<=pc+imm_b. Not taken: pc+4.
  - JAL: rd<=pc+4, pc<=pc+imm_j.
  - JALR: pc<=(rs1+imm_i)&~1, using rs1 read before the rd write (rd==rs1 safe).
- Byte lanes (ea = rs1+imm):
  - Byte access: mask 4'b0001<<ea[1:0].
  - Half access: ea[0] is ignored; mask 4'b0011<<{ea[1],1'b0}.
  - Word access: ea[1:0] ignored; mask 4'b1111.
  - Store data is replicated/shifted into the active lanes.
  - Loads extract the addressed lane and sign- or zero-extend per funct3.
- Reset mid-access (MEM state): abandon the access. Requests deassert in the same cycle as the reset edge takes effect, with no writeback.
- Any imem_resp arriving while in MEM is ignored.

Optional Feature:
- Macro ONE_HZ_CPU_TRACE_EN. When defined, three extra outputs are present: trace_valid (1), trace_rd (5), trace_rd_wdata (32).
  - trace_valid=1 for exactly the cycle an instruction retires, combinationally with the retiring edge.
  - trace_rd/trace_rd_wdata carry the destination and the written value; trace_rd=0 for no-write instructions.
- When not defined, these ports and their logic do not exist. Core behaviour is identical either way.

Test Plan:
- Reset for 5 cycles -> pc=32'h60, imem_read=0, mem_read=mem_write=0. After release, imem_read=1.
- imem_resp=1 each cycle; feed in sequence:
  - ADDI x1,x0,15; x2,31; x3,63; x4,127; x5,255; x7,511; x8,1023; x9,2047.
  - Then ADD x10,x2,x1.
  - Required: x1..x9 hold 15..2047 (x6 stays 0), x10=46, one retire per cycle, pc=32'h60+4*9=32'h84 after the last.
- SW x1,3(x0) with x1=32'hAABBCCDD, mem_resp after 3 cycles -> mem_address=0, mbe=4'b1111, wdata=32'hAABBCCDD held for 3 cycles; pc advances only on mem_resp.
- LB x5,1(x0) with mem_rdata=32'h0000_8000 -> mbe=4'b0010, x5=32'hFFFFFF80. LBU gives 32'h80.
- BNE x1,x2,-8 with x1≠x2 at pc=32'h70 -> pc=32'h68. With x1==x2 -> pc=32'h74.
- ADDI x0,x0,5 -> x0 stays 0. Holding imem_resp=0 for 4 cycles -> pc stable, no register change.
